fir_filter_checker: RTL and testbench

//  Self-checking sequencer and scoreboard for the FIR filter simulation bench.
//  - Generates vector_address for the vector-memory stimulus block.
//  - Compares the filter output against the expected-output stream; counts compares and mismatches.
//  - Reports pass/fail once every vector has been applied and the compare pipeline has drained.

---
 rtl/fir_filter_checker_pkg.sv | 15 +
 rtl/fir_checker_delay_line.sv | 29 ++
 rtl/fir_filter_checker.sv | 132 +++++++++++++
 tb/tb_fir_filter_checker.sv | 201 ++++++++++++++++++++
 4 files changed

// File: rtl/fir_filter_checker_pkg.sv
// Shared definitions for the FIR filter bench checker and its stimulus block:
// FSM state encoding and the default data/address widths.
package fir_filter_checker_pkg;

  localparam int DEF_TEST_OUTPUT_WIDTH = 38;
  localparam int DEF_VECTOR_ADDR_BITS  = 16;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } state_t;

endpackage

// File: rtl/fir_checker_delay_line.sv
// Fixed-depth shift register carrying {valid, addr} from address issue to the
// cycle in which the matching dut_y/exp_y pair is presented.
module fir_checker_delay_line #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 17
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout
);

  logic [WIDTH-1:0] stages [DEPTH];

  // Shift one stage per cycle; every stage starts empty (valid=0).
  // NOTE: this array is reset on purpose - a stale valid bit left over from an
  // aborted run would otherwise trigger a bogus compare after restart.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      for (int i = 0; i < DEPTH; i++) stages[i] <= '0;
    end else begin
      stages[0] <= din;
      for (int i = 1; i < DEPTH; i++) stages[i] <= stages[i-1];
    end
  end

  assign dout = stages[DEPTH-1];

endmodule

// File: rtl/fir_filter_checker.sv
// Sequencer and scoreboard for the FIR filter bench: issues vector addresses,
// compares aligned dut_y/exp_y, counts compares and mismatches, reports pass.
// Optional feature macro: FIR_CHECKER_FIRST_ERR_EN (capture the address of
// the first mismatch on first_err_addr; otherwise first_err_addr is 0).
module fir_filter_checker
  import fir_filter_checker_pkg::*;
#(
  parameter int TEST_OUTPUT_WIDTH = DEF_TEST_OUTPUT_WIDTH,
  parameter int NUM_VECTORS       = 65536,
  parameter int VECTOR_ADDR_BITS  = DEF_VECTOR_ADDR_BITS,
  parameter int COMPARE_LATENCY   = 4,
  parameter int WARMUP            = 16,
  parameter int ERR_CNT_WIDTH     = 16
) (
  input  logic                         clk,
  input  logic                         resetn,
  input  logic                         start,
  output logic [VECTOR_ADDR_BITS-1:0]  vector_address,
  input  logic [TEST_OUTPUT_WIDTH-1:0] dut_y,
  input  logic [TEST_OUTPUT_WIDTH-1:0] exp_y,
  output logic                         busy,
  output logic                         done,
  output logic                         pass,
  output logic [ERR_CNT_WIDTH-1:0]     error_count,
  output logic [VECTOR_ADDR_BITS:0]    compare_count,
  output logic [VECTOR_ADDR_BITS-1:0]  first_err_addr
);

  localparam logic [VECTOR_ADDR_BITS-1:0] LAST_ADDR = VECTOR_ADDR_BITS'(NUM_VECTORS - 1);
  localparam int                          DCW        = $clog2(COMPARE_LATENCY + 1);
  localparam logic [DCW-1:0]              DRAIN_LAST = DCW'(COMPARE_LATENCY - 1);

  state_t                      state, state_nxt;
  logic                        start_run;
  logic [VECTOR_ADDR_BITS-1:0] addr_q;
  logic [DCW-1:0]              drain_cnt;
  logic [VECTOR_ADDR_BITS:0]   line_in, line_out;
  logic                        line_valid;
  logic [VECTOR_ADDR_BITS-1:0] line_addr;
  logic                        cmp_en;
  logic                        mismatch;

  // State register.
  // NOTE: sequential state uses non-blocking assignments so every flop
  // samples pre-edge values regardless of process ordering.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) state <= IDLE;
    else         state <= state_nxt;
  end

  // Next-state logic; start is only honoured from IDLE or DONE.
  // NOTE: defaults come first so no path leaves a signal unassigned (no latch).
  always_comb begin
    state_nxt = state;
    start_run = 1'b0;
    case (state)
      IDLE, DONE: if (start) begin
        state_nxt = RUN;
        start_run = 1'b1;
      end
      RUN:   if (addr_q == LAST_ADDR)     state_nxt = DRAIN;
      DRAIN: if (drain_cnt == DRAIN_LAST) state_nxt = DONE;
      default: state_nxt = IDLE;
    endcase
  end

  // Address issue: restart at 0, step once per RUN cycle, hold the last value.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn)                                addr_q <= '0;
    else if (start_run)                         addr_q <= '0;
    else if (state == RUN && addr_q != LAST_ADDR) addr_q <= addr_q + 1'b1;
  end

  // Drain timer: counts the empty pushes that flush the delay line.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn)             drain_cnt <= '0;
    else if (state == DRAIN) drain_cnt <= drain_cnt + 1'b1;
    else                     drain_cnt <= '0;
  end

  assign line_in = {state == RUN, addr_q};

  fir_checker_delay_line #(
    .DEPTH (COMPARE_LATENCY),
    .WIDTH (VECTOR_ADDR_BITS + 1)
  ) u_delay_line (
    .clk    (clk),
    .resetn (resetn),
    .din    (line_in),
    .dout   (line_out)
  );

  assign line_valid = line_out[VECTOR_ADDR_BITS];
  assign line_addr  = line_out[VECTOR_ADDR_BITS-1:0];
  assign cmp_en     = line_valid && (int'(line_addr) >= WARMUP);
  assign mismatch   = (dut_y != exp_y);

  // Scoreboard counters; the error counter saturates instead of wrapping.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      compare_count <= '0;
      error_count   <= '0;
    end else if (start_run) begin
      compare_count <= '0;
      error_count   <= '0;
    end else if (cmp_en) begin
      compare_count <= compare_count + 1'b1;
      if (mismatch && error_count != '1) error_count <= error_count + 1'b1;
    end
  end

`ifdef FIR_CHECKER_FIRST_ERR_EN
  logic [VECTOR_ADDR_BITS-1:0] first_err_q;

  // Capture the address of the first mismatch only (error_count still zero).
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn)                                    first_err_q <= '0;
    else if (start_run)                             first_err_q <= '0;
    else if (cmp_en && mismatch && error_count == '0) first_err_q <= line_addr;
  end

  assign first_err_addr = first_err_q;
`else
  assign first_err_addr = '0;
`endif

  assign vector_address = addr_q;
  assign busy           = (state == RUN) || (state == DRAIN);
  assign done           = (state == DONE);
  assign pass           = done && (error_count == '0);

endmodule

// File: tb/tb_fir_filter_checker.sv
// Directed bench for fir_filter_checker: two instances share stimulus, one
// with a 2-bit error counter to exercise saturation.
module tb_fir_filter_checker;

  localparam int NV = 64;
  localparam int AB = 6;
  localparam int W  = 38;
  localparam int L  = 4;
  localparam int WU = 16;

  logic          clk = 1'b0;
  logic          resetn = 1'b0;
  logic          start = 1'b0;
  logic [W-1:0]  dut_y, exp_y;
  logic [NV-1:0] bad_mask = '0;
  logic [AB-1:0] pipe [L];
  logic [AB-1:0] aligned;

  logic [AB-1:0] va1, fe1, va2, fe2;
  logic          busy1, done1, pass1, busy2, done2, pass2;
  logic [15:0]   err1;
  logic [1:0]    err2;
  logic [AB:0]   cnt1, cnt2;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  // Bench-side alignment: the address issued L cycles ago owns this data pair.
  always @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      for (int i = 0; i < L; i++) pipe[i] <= '0;
    end else begin
      pipe[0] <= va1;
      for (int i = 1; i < L; i++) pipe[i] <= pipe[i-1];
    end
  end

  assign aligned = pipe[L-1];
  assign exp_y   = {2'b10, 30'h1555_5555, aligned};
  assign dut_y   = bad_mask[aligned] ? (exp_y ^ {1'b1, {(W-1){1'b0}}}) : exp_y;

  fir_filter_checker #(
    .TEST_OUTPUT_WIDTH (W), .NUM_VECTORS (NV), .VECTOR_ADDR_BITS (AB),
    .COMPARE_LATENCY (L), .WARMUP (WU), .ERR_CNT_WIDTH (16)
  ) u_dut1 (
    .clk (clk), .resetn (resetn), .start (start), .vector_address (va1),
    .dut_y (dut_y), .exp_y (exp_y), .busy (busy1), .done (done1), .pass (pass1),
    .error_count (err1), .compare_count (cnt1), .first_err_addr (fe1)
  );

  fir_filter_checker #(
    .TEST_OUTPUT_WIDTH (W), .NUM_VECTORS (NV), .VECTOR_ADDR_BITS (AB),
    .COMPARE_LATENCY (L), .WARMUP (WU), .ERR_CNT_WIDTH (2)
  ) u_dut2 (
    .clk (clk), .resetn (resetn), .start (start), .vector_address (va2),
    .dut_y (dut_y), .exp_y (exp_y), .busy (busy2), .done (done2), .pass (pass2),
    .error_count (err2), .compare_count (cnt2), .first_err_addr (fe2)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    assert (got === exp)
    else begin
      errors++;
      $error("FAIL %s got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic pulse_start();
    @(negedge clk) start = 1'b1;
    @(negedge clk) start = 1'b0;
  endtask

  // Called at the negedge after the start edge; counts edges until done.
  task automatic run_to_done(input int exp_cyc, input string tag);
    int cyc = 0;
    bit pass_busy = 1'b0;
    while (!done1 && cyc < 300) begin
      @(negedge clk);
      cyc++;
      if ((pass1 && busy1) || (pass2 && busy2)) pass_busy = 1'b1;
    end
    check({tag, "_cycles"}, 64'(cyc), 64'(exp_cyc));
    check({tag, "_pass_while_busy"}, 64'(pass_busy), 64'd0);
    check({tag, "_done2"}, 64'(done2), 64'd1);
    check({tag, "_busy"}, 64'(busy1), 64'd0);
    check({tag, "_addr_hold"}, 64'(va1), 64'(NV - 1));
  endtask

  task automatic check_zero(input string tag);
    check({tag, "_va"},   64'(va1),   64'd0);
    check({tag, "_busy"}, 64'(busy1), 64'd0);
    check({tag, "_done"}, 64'(done1), 64'd0);
    check({tag, "_pass"}, 64'(pass1), 64'd0);
    check({tag, "_err"},  64'(err1),  64'd0);
    check({tag, "_cnt"},  64'(cnt1),  64'd0);
    check({tag, "_fe"},   64'(fe1),   64'd0);
    check({tag, "_err2"}, 64'(err2),  64'd0);
  endtask

  task automatic check_result(input string tag, input int e1, input int e2, input int fe, input bit p);
    check({tag, "_cnt"},   64'(cnt1),  64'd48);
    check({tag, "_cnt2"},  64'(cnt2),  64'd48);
    check({tag, "_err"},   64'(err1),  64'(e1));
    check({tag, "_err2"},  64'(err2),  64'(e2));
    check({tag, "_pass"},  64'(pass1), 64'(p));
    check({tag, "_pass2"}, 64'(pass2), 64'(p));
`ifdef FIR_CHECKER_FIRST_ERR_EN
    check({tag, "_fe"},    64'(fe1),   64'(fe));
`else
    check({tag, "_fe"},    64'(fe1),   64'd0);
`endif
  endtask

  initial begin
    int cyc;

    // Reset state.
    #12;
    check_zero("reset");
    @(negedge clk) resetn = 1'b1;
    @(negedge clk);
    check_zero("idle");

    // 1: all vectors match.
    bad_mask = '0;
    pulse_start();
    check("s1_busy_at_start", 64'(busy1), 64'd1);
    check("s1_addr_at_start", 64'(va1), 64'd0);
    run_to_done(NV + L, "s1");
    check_result("s1", 0, 0, 0, 1'b1);

    // 2: mismatches at 20 and 40 (restart from DONE).
    bad_mask = '0;
    bad_mask[20] = 1'b1;
    bad_mask[40] = 1'b1;
    pulse_start();
    check("s2_cleared_cnt", 64'(cnt1), 64'd0);
    run_to_done(NV + L, "s2");
    check_result("s2", 2, 2, 20, 1'b0);

    // 3: mismatches only inside warmup.
    bad_mask = '0;
    bad_mask[15:0] = '1;
    pulse_start();
    run_to_done(NV + L, "s3");
    check_result("s3", 0, 0, 0, 1'b1);

    // 4: every compare mismatches; the 2-bit counter saturates at 3.
    bad_mask = '1;
    pulse_start();
    run_to_done(NV + L, "s4");
    check_result("s4", 48, 3, 16, 1'b0);

    // 5: reset mid-run at address 30, then a clean run.
    bad_mask = '1;
    pulse_start();
    cyc = 0;
    while (va1 != 6'd30 && cyc < 100) begin
      @(negedge clk);
      cyc++;
    end
    check("s5_reached_30", 64'(va1), 64'd30);
    resetn = 1'b0;
    #1;
    check_zero("s5_in_reset");
    @(negedge clk);
    check_zero("s5_held_reset");
    resetn = 1'b1;
    bad_mask = '0;
    pulse_start();
    run_to_done(NV + L, "s5");
    check_result("s5", 0, 0, 0, 1'b1);

    // 6: start during RUN is ignored; start in DONE restarts cleanly.
    bad_mask = '1;
    pulse_start();
    repeat (9) @(negedge clk);
    pulse_start();
    check("s6_ignored_addr", 64'(va1), 64'd11);
    check("s6_ignored_busy", 64'(busy1), 64'd1);
    run_to_done(NV + L - 11, "s6a");
    check_result("s6a", 48, 3, 16, 1'b0);
    bad_mask = '0;
    bad_mask[50] = 1'b1;
    pulse_start();
    check("s6_restart_addr", 64'(va1), 64'd0);
    check("s6_restart_cnt", 64'(cnt1), 64'd0);
    check("s6_restart_err", 64'(err1), 64'd0);
    check("s6_restart_done", 64'(done1), 64'd0);
    check("s6_restart_fe", 64'(fe1), 64'd0);
    run_to_done(NV + L, "s6b");
    check_result("s6b", 1, 1, 50, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
